async_fifo_rd_ctrl: RTL and testbench

Read-side controller for the dual-clock FIFO, placed in the read clock domain between the write-side controller and the dual-port RAM. It synchronises the write pointer (Gray) internally and maintains the read pointer in binary and Gray. It produces registered empty, almost-empty, fill level and read-valid, with an optional underflow monitor. Successor to the current read-pointer/empty block: adds the built-in synchroniser, a full-range fill count, a programmable almost-empty threshold and a show-ahead addressing mode.

---
 rtl/async_fifo_rd_ctrl.sv | 102 ++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller for the dual-clock FIFO: write-pointer synchroniser, read pointer, flags.
// Optional sticky underflow monitor is built when RD_CTRL_UNDERFLOW_EN is defined.
module async_fifo_rd_ctrl #(
    parameter int unsigned AWIDTH           = 3,
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned ALMOST_EMPTY_LVL = 1,
    parameter int unsigned SHOWAHEAD        = 0
) (
    input  logic              rd_clk_i,
    input  logic              aclr_i,
    input  logic              rd_req_i,
    input  logic [AWIDTH:0]   wr_pntr_gray_i,
    output logic [AWIDTH-1:0] rd_pntr_o,
    output logic [AWIDTH:0]   rd_pntr_gray_o,
    output logic              rd_empty_o,
    output logic              rd_almost_empty_o,
    output logic [AWIDTH:0]   rd_usedw_o,
    output logic              rd_valid_o,
    output logic              rd_underflow_o
);

    localparam logic [AWIDTH:0] AeLvl = (AWIDTH + 1)'(ALMOST_EMPTY_LVL);

    logic [AWIDTH:0] sync_q [SYNC_STAGES];
    logic [AWIDTH:0] wr_sync_gray;
    logic [AWIDTH:0] wr_sync_bin;
    logic [AWIDTH:0] rd_bin_q;
    logic [AWIDTH:0] rd_bin_next;
    logic [AWIDTH:0] rd_gray_next;
    logic [AWIDTH:0] usedw_next;
    logic            accept;

    always_ff @(posedge rd_clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_pntr_gray_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_sync_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        wr_sync_bin = '0;
        for (int k = 0; k <= int'(AWIDTH); k++) begin
            wr_sync_bin[k] = ^(wr_sync_gray >> k);
        end
    end

    assign accept       = rd_req_i & ~rd_empty_o;
    assign rd_bin_next  = rd_bin_q + (AWIDTH + 1)'(accept);
    assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
    // Modulo subtraction over AWIDTH+1 bits keeps a full FIFO at 2^AWIDTH rather than 0.
    assign usedw_next   = wr_sync_bin - rd_bin_next;

    always_ff @(posedge rd_clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            rd_bin_q          <= '0;
            rd_pntr_gray_o    <= '0;
            rd_empty_o        <= 1'b1;
            rd_almost_empty_o <= 1'b1;
            rd_usedw_o        <= '0;
            rd_valid_o        <= 1'b0;
        end else begin
            rd_bin_q          <= rd_bin_next;
            rd_pntr_gray_o    <= rd_gray_next;
            rd_empty_o        <= (rd_gray_next == wr_sync_gray);
            rd_almost_empty_o <= (usedw_next <= AeLvl);
            rd_usedw_o        <= usedw_next;
            rd_valid_o        <= accept;
        end
    end

    if (SHOWAHEAD != 0) begin : g_showahead
        // Address the next word early so a registered-output RAM already shows the head word.
        assign rd_pntr_o = rd_bin_next[AWIDTH-1:0];
    end else begin : g_normal
        assign rd_pntr_o = rd_bin_q[AWIDTH-1:0];
    end

`ifdef RD_CTRL_UNDERFLOW_EN
    logic underflow_q;

    always_ff @(posedge rd_clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            underflow_q <= 1'b0;
        end else if (rd_req_i & rd_empty_o) begin
            underflow_q <= 1'b1;
        end
    end

    assign rd_underflow_o = underflow_q;
`else
    assign rd_underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl: normal and show-ahead instances share one stimulus.
module tb_async_fifo_rd_ctrl;

    logic       clk;
    logic       aclr;
    logic       req;
    logic [3:0] wr_gray;

    logic [2:0] pntr, sa_pntr;
    logic [3:0] gray, sa_gray;
    logic       empty, sa_empty;
    logic       ae, sa_ae;
    logic [3:0] usedw, sa_usedw;
    logic       valid, sa_valid;
    logic       uflow, sa_uflow;

    int errors = 0;
    int checks = 0;

    logic [2:0] exp_pntr6  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5};
    logic [3:0] exp_used6  [6] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    logic       exp_ae6    [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_empty6 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       exp_valid6 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] exp_wrap_pntr [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [3:0] exp_wrap_gray [4] = '{4'b1000, 4'b0000, 4'b0001, 4'b0011};
    logic       exp_uflow;
    int         pulses;

    async_fifo_rd_ctrl #(
        .AWIDTH(3), .SYNC_STAGES(2), .ALMOST_EMPTY_LVL(1), .SHOWAHEAD(0)
    ) dut (
        .rd_clk_i(clk), .aclr_i(aclr), .rd_req_i(req), .wr_pntr_gray_i(wr_gray),
        .rd_pntr_o(pntr), .rd_pntr_gray_o(gray), .rd_empty_o(empty),
        .rd_almost_empty_o(ae), .rd_usedw_o(usedw), .rd_valid_o(valid),
        .rd_underflow_o(uflow)
    );

    async_fifo_rd_ctrl #(
        .AWIDTH(3), .SYNC_STAGES(2), .ALMOST_EMPTY_LVL(1), .SHOWAHEAD(1)
    ) dut_sa (
        .rd_clk_i(clk), .aclr_i(aclr), .rd_req_i(req), .wr_pntr_gray_i(wr_gray),
        .rd_pntr_o(sa_pntr), .rd_pntr_gray_o(sa_gray), .rd_empty_o(sa_empty),
        .rd_almost_empty_o(sa_ae), .rd_usedw_o(sa_usedw), .rd_valid_o(sa_valid),
        .rd_underflow_o(sa_uflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_ae"}, 32'(ae), 1);
        check({tag, "_usedw"}, 32'(usedw), 0);
        check({tag, "_pntr"}, 32'(pntr), 0);
        check({tag, "_gray"}, 32'(gray), 0);
        check({tag, "_valid"}, 32'(valid), 0);
        check({tag, "_uflow"}, 32'(uflow), 0);
        check({tag, "_sa_pntr"}, 32'(sa_pntr), 0);
        check({tag, "_sa_empty"}, 32'(sa_empty), 1);
    endtask

    initial begin
`ifdef RD_CTRL_UNDERFLOW_EN
        exp_uflow = 1'b1;
`else
        exp_uflow = 1'b0;
`endif
        aclr    = 1'b1;
        req     = 1'b0;
        wr_gray = 4'b0000;
        #2;
        check_reset("rst");
        tick();
        aclr = 1'b0;

        // Write pointer at 5: flags move only on the third edge.
        wr_gray = 4'b0111;
        tick();
        tick();
        check("sync_lat_empty", 32'(empty), 1);
        tick();
        check("fill5_usedw", 32'(usedw), 5);
        check("fill5_empty", 32'(empty), 0);
        check("fill5_ae", 32'(ae), 0);

        req = 1'b1;
        #1;
        check("sa_lookahead", 32'(sa_pntr), 1);
        check("norm_pntr_hold", 32'(pntr), 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid) pulses++;
            check($sformatf("b2b%0d_usedw", i), 32'(usedw), 32'(exp_used6[i]));
            check($sformatf("b2b%0d_ae", i), 32'(ae), 32'(exp_ae6[i]));
            check($sformatf("b2b%0d_empty", i), 32'(empty), 32'(exp_empty6[i]));
            check($sformatf("b2b%0d_valid", i), 32'(valid), 32'(exp_valid6[i]));
            check($sformatf("b2b%0d_pntr", i), 32'(pntr), 32'(exp_pntr6[i]));
            if (i == 4) check("sa_empty_hold", 32'(sa_pntr), 5);
        end
        check("valid_pulses", 32'(pulses), 5);
        check("underflow", 32'(uflow), 32'(exp_uflow));
        req = 1'b0;

        // Full FIFO from a fresh reset: write pointer at 8.
        aclr = 1'b1;
        #1;
        aclr = 1'b0;
        check("rst2_uflow", 32'(uflow), 0);
        wr_gray = 4'b1100;
        repeat (3) tick();
        check("full_usedw", 32'(usedw), 8);
        check("full_empty", 32'(empty), 0);
        check("full_ae", 32'(ae), 0);

        req = 1'b1;
        repeat (8) tick();
        req = 1'b0;
        check("drain8_empty", 32'(empty), 1);
        check("drain8_usedw", 32'(usedw), 0);
        check("drain8_gray", 32'(gray), 32'h0c);

        // Move read pointer to 14, then write pointer wraps to 2.
        wr_gray = 4'b1001;
        repeat (3) tick();
        check("fill6_usedw", 32'(usedw), 6);
        req = 1'b1;
        repeat (6) tick();
        req = 1'b0;
        check("at14_empty", 32'(empty), 1);
        check("at14_pntr", 32'(pntr), 6);
        check("at14_gray", 32'(gray), 32'h09);

        wr_gray = 4'b0011;
        repeat (3) tick();
        check("wrap_usedw", 32'(usedw), 4);
        check("wrap_empty", 32'(empty), 0);
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap%0d_pntr", i), 32'(pntr), 32'(exp_wrap_pntr[i]));
            tick();
            check($sformatf("wrap%0d_gray", i), 32'(gray), 32'(exp_wrap_gray[i]));
        end
        req = 1'b0;
        check("wrap_end_empty", 32'(empty), 1);
        check("wrap_end_usedw", 32'(usedw), 0);

        // Three words queued, then asynchronous clear in the middle of a read cycle.
        wr_gray = 4'b0111;
        repeat (3) tick();
        check("mid_usedw", 32'(usedw), 3);
        req = 1'b1;
        #1;
        check("mid_sa_pntr", 32'(sa_pntr), 3);
        check("mid_norm_pntr", 32'(pntr), 2);
        #2;
        aclr = 1'b1;
        #1;
        check_reset("aclr_mid");
        req  = 1'b0;
        aclr = 1'b0;
        tick();
        check("post_aclr_empty", 32'(empty), 1);
        check("post_aclr_usedw", 32'(usedw), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
